// File: rtl/map_share_arbiter_pkg.sv
// map_share_pkg: shared types and constants for map_share_arbiter.
//   state_e    : FSM encoding (IDLE=00, EVAL=01, RESP=10)
//   OP_W/RES_W : operand and result widths of the code map
//   MAP_TABLE  : fixed 3-bit -> 4-bit map, entry i at bits [4i+3:4i]
package map_share_pkg;

    localparam int OP_W  = 3;
    localparam int RES_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Listed from entry 7 down to entry 0:
    // 7->9, 6->1, 5->3, 4->0, 3->6, 2->7, 1->9, 0->1
    localparam logic [8*RES_W-1:0] MAP_TABLE =
        {4'd9, 4'd1, 4'd3, 4'd0, 4'd6, 4'd7, 4'd9, 4'd1};

endpackage

// File: rtl/map_share_arbiter_if.sv
// map_share_arbiter_if: request/grant and response handshake bundle.
//   req, req_data, rsp_ready : driven by requesters / consumer (master)
//   gnt, rsp_valid, rsp_id, rsp_data : driven by the arbiter (slave)
interface map_share_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) ();
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_data;

    modport master (
        output req, req_data, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, req_data, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/map_share_arbiter_code_map.sv
// code_map: purely combinational fixed code map.
//   code_in  [2:0] : operand
//   code_out [3:0] : mapped result from MAP_TABLE
module code_map
    import map_share_pkg::*;
(
    input  logic [OP_W-1:0]  code_in,
    output logic [RES_W-1:0] code_out
);
    always_comb begin
        code_out = RES_W'(MAP_TABLE >> (int'(code_in) * RES_W));
    end
endmodule

// File: rtl/map_share_arbiter.sv
// map_share_arbiter: round-robin sharing of one code_map among NREQ
// requesters, with a registered tagged result under valid/ready.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : map_share_arbiter_if.slave (req/req_data/gnt/rsp_*)
// Optional (macro MAP_SHARE_STATS_EN):
//   svc_count [7:0] : completed handshakes, wraps 255->0
//   busy            : high while in EVAL or RESP
//
// state | meaning
// IDLE  | waiting for any req; arbitrates and grants on the edge
// EVAL  | gnt high this cycle; map of the latched operand is registered
// RESP  | rsp_valid held until rsp_ready
module map_share_arbiter
    import map_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic clk,
    input  logic rst,
    map_share_arbiter_if.slave bus
`ifdef MAP_SHARE_STATS_EN
    ,
    output logic [7:0] svc_count,
    output logic       busy
`endif
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] EVAL = ST_EVAL;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_reg;
    logic [OP_W-1:0]  op_reg;
    logic [RES_W-1:0] map_out;

    logic             win_found;
    int               win_idx;
    int               scan_idx;
    logic [NREQ-1:0]  req_shift;

    code_map u_code_map (
        .code_in  (op_reg),
        .code_out (map_out)
    );

    // First set request scanning upward from rr_ptr, wrapping at NREQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        scan_idx  = 0;
        req_shift = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            req_shift = bus.req >> scan_idx;
            if (!win_found && req_shift[0]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_reg        <= '0;
            op_reg        <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.gnt <= NREQ'(1) << win_idx;
                        op_reg  <= OP_W'(bus.req_data >> (win_idx * OP_W));
                        id_reg  <= IDW'(win_idx);
                        rr_ptr  <= (win_idx == NREQ - 1) ? '0 : IDW'(win_idx + 1);
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    bus.gnt       <= '0;
                    bus.rsp_data  <= map_out;
                    bus.rsp_id    <= id_reg;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    // rsp_id/rsp_data deliberately keep their values afterwards
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAP_SHARE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            svc_count <= '0;
        end else if (state == RESP && bus.rsp_ready) begin
            svc_count <= svc_count + 8'd1;
        end
    end

    assign busy = (state == EVAL) || (state == RESP);
`endif

endmodule
